// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and byte helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] IO_SEL = 2'b11;

    // Encoding 3 is undefined for the LSU and is served as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF and LS requests onto the shared
// 8-bit bus, honouring RAM read latency, rdy_in pauses and I/O back-pressure.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IO_HI  = 17,
    parameter int IO_GAP = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    localparam int GAP_W = (IO_GAP > 0) ? $clog2(IO_GAP + 1) : 1;

    state_t            state;
    owner_t            owner;
    logic [2:0]        k;
    logic [2:0]        n;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic [31:0]       asm_word;
    logic [GAP_W-1:0]  gap;
    logic              if_done_q;
    logic              ls_done_q;
    logic              done_is_read;

    logic [ADDR_W-1:0] cur_a;
    logic              cur_io;
    logic              wr_fire;
    logic [1:0]        cap_idx;
    logic [31:0]       read_word;

    assign cur_a     = base + ADDR_W'(k);
    assign cur_io    = (cur_a[IO_HI:IO_HI-1] == IO_SEL);
    assign cap_idx   = 2'(k - 3'd1);
    assign read_word = put_byte(asm_word, cap_idx, mem_din);

    // A write byte leaves only when the host is not on the bus and, for I/O,
    // the transmit buffer has room and the inter-write gap has elapsed.
    assign wr_fire = (state == ST_WRITE) && rdy_in &&
                     !(cur_io && (io_buffer_full || gap != '0));

    // Read done pulses are dropped while a flush is visible in the same cycle.
    assign if_done = if_done_q & ~flush_in;
    assign ls_done = ls_done_q & ~(flush_in & done_is_read);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        case (state)
            ST_READ: begin
                if (k < n) mem_a = cur_a;
            end
            ST_WRITE: begin
                mem_a    = cur_a;
                mem_dout = get_byte(wdata, k[1:0]);
                mem_wr   = wr_fire;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every branch sees
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= ST_IDLE;
            owner        <= OWN_IF;
            k            <= '0;
            n            <= '0;
            base         <= '0;
            wdata        <= '0;
            asm_word     <= '0;
            gap          <= '0;
            if_done_q    <= 1'b0;
            ls_done_q    <= 1'b0;
            done_is_read <= 1'b0;
            if_data      <= '0;
            ls_rdata     <= '0;
        end else begin
            if_done_q    <= 1'b0;
            ls_done_q    <= 1'b0;
            done_is_read <= 1'b0;

            if (rdy_in && gap != '0) gap <= gap - GAP_W'(1);

            case (state)
                ST_IDLE: begin
                    if (rdy_in && !flush_in && !if_done_q && !ls_done_q) begin
                        if (ls_req) begin
                            owner    <= OWN_LS;
                            base     <= ls_addr;
                            wdata    <= ls_wdata;
                            n        <= size_bytes(ls_size);
                            k        <= '0;
                            asm_word <= '0;
                            state    <= ls_wr ? ST_WRITE : ST_READ;
                        end else if (if_req) begin
                            owner    <= OWN_IF;
                            base     <= if_addr;
                            n        <= 3'd4;
                            k        <= '0;
                            asm_word <= '0;
                            state    <= ST_READ;
                        end
                    end
                end

                ST_READ: begin
                    if (flush_in) begin
                        state <= ST_IDLE;
                        k     <= '0;
                    end else if (!rdy_in) begin
                        // Bytes on mem_din are not trusted across a pause.
                        k <= '0;
                    end else begin
                        if (k != 3'd0) asm_word <= read_word;
                        if (k == n) begin
                            state <= ST_IDLE;
                            k     <= '0;
                            if (owner == OWN_IF) begin
                                if_data   <= read_word;
                                if_done_q <= 1'b1;
                            end else begin
                                ls_rdata     <= read_word;
                                ls_done_q    <= 1'b1;
                                done_is_read <= 1'b1;
                            end
                        end else begin
                            k <= k + 3'd1;
                        end
                    end
                end

                ST_WRITE: begin
                    if (wr_fire) begin
                        if (cur_io) gap <= GAP_W'(IO_GAP);
                        if (k == n - 3'd1) begin
                            state     <= ST_IDLE;
                            k         <= '0;
                            ls_done_q <= 1'b1;
                        end else begin
                            k <= k + 3'd1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
